// File: rtl/exec_cmd_pkg.sv
// Shared constants and types for the command executor and its RAM models.
package exec_cmd_pkg;

    localparam logic [3:0]  OP_NOP          = 4'd0;
    localparam logic [3:0]  OP_WRITE        = 4'd1;
    localparam logic [3:0]  OP_READ         = 4'd2;
    localparam logic [3:0]  OP_DELAY        = 4'd3;
    localparam logic [15:0] MAGIC_WORD      = 16'hCBAE;
    localparam int          DEFAULT_TIMEOUT = 255;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_LEN, S_FETCH, S_DECODE, S_ARG, S_REG_WR, S_REG_RD,
        S_STORE_HI, S_STORE_LO, S_DELAY, S_DONE
    } state_e;

endpackage

// File: rtl/generic_spram.sv
// Single-port RAM model; the read pipeline only loads a new word when re is high.
module generic_spram #(
    parameter int LAT = 1,
    parameter int AW  = 10,
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] q
);
    logic [DW-1:0] mem    [1 << AW];
    logic [DW-1:0] pipe_q [LAT];

    // storage write and read pipeline
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= data;
        end
        if (re) begin
            pipe_q[0] <= mem[addr];
        end
        for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q = pipe_q[LAT-1];
endmodule

// File: rtl/inputram.sv
// Synthesis-facing command RAM wrapper with vendor-style port names.
module inputram #(
    parameter int AW = 10
) (
    input  logic [AW-1:0] address,
    input  logic          clock,
    input  logic [15:0]   data,
    input  logic          rden,
    input  logic          wren,
    output logic [15:0]   q
);
    generic_spram #(.LAT(1), .AW(AW), .DW(16)) u_ram (
        .clk  (clock),
        .re   (rden),
        .we   (wren),
        .addr (address),
        .data (data),
        .q    (q)
    );
endmodule

// File: rtl/exec_cmd.sv
// Command executor: walks the command RAM, issues register-bus WRITE/READ/DELAY
// commands and appends READ results after the magic word in the result RAM.
module exec_cmd
    import exec_cmd_pkg::*;
#(
    parameter int AW      = 10,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] inram_address,
    output logic          inram_re,
    input  logic [15:0]   inram_q,
    output logic [AW-1:0] outram_address,
    output logic          outram_we,
    output logic [15:0]   outram_d,
    output logic [13:0]   reg_addr_c2,
    output logic          reg_rd_c2,
    output logic          reg_wr_c2,
    output logic [31:0]   reg_writedata_c2,
    input  logic          reg_ready_c2,
    input  logic [31:0]   reg_readdata_c2,
    input  logic          start_exec,
    output logic          busy,
    output logic          err,
    output logic [AW-1:0] out_len
);
    localparam logic [31:0] ADDR_MAX   = 32'((1 << AW) - 1);
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d, len_q, len_d, out_len_q, out_len_d;
    logic [AW-1:0] in_addr_q, in_addr_d, out_addr_q, out_addr_d;
    logic [3:0]    op_q, op_d;
    logic [1:0]    argi_q, argi_d;
    logic [15:0]   cnt_q, cnt_d, out_data_q, out_data_d;
    logic [13:0]   reg_addr_q, reg_addr_d;
    logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic          rvalid_q, re_q, re_d, we_q, we_d, busy_q, busy_d, err_q, err_d;
    logic          reg_rd_q, reg_rd_d, reg_wr_q, reg_wr_d;
    logic          fail_s, need_arg_s, arg_oob_s;

    // next-state and output computation
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        out_len_d  = out_len_q;
        in_addr_d  = in_addr_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        op_d       = op_q;
        argi_d     = argi_q;
        cnt_d      = cnt_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        err_d      = err_q;
        reg_rd_d   = reg_rd_q;
        reg_wr_d   = reg_wr_q;
        re_d       = 1'b0;
        we_d       = 1'b0;
        fail_s     = 1'b0;
        need_arg_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_exec) begin
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    out_len_d  = '0;
                    we_d       = 1'b1;
                    out_addr_d = '0;
                    out_data_d = MAGIC_WORD;
                    re_d       = 1'b1;
                    in_addr_d  = '0;
                    state_d    = S_RD_LEN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_LEN: begin
                if (rvalid_q) begin
                    if ((inram_q < 16'd2) || (32'(inram_q) > ADDR_MAX)) begin
                        fail_s = 1'b1;
                    end else begin
                        len_d   = inram_q[AW-1:0];
                        ptr_d   = AW'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_RD_LEN;
                end
            end
            S_FETCH: begin
                // the terminator word itself is never read
                if (ptr_q == len_q) begin
                    state_d = S_DONE;
                end else begin
                    re_d      = 1'b1;
                    in_addr_d = ptr_q;
                    ptr_d     = ptr_q + AW'(1);
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (rvalid_q) begin
                    op_d   = inram_q[15:12];
                    argi_d = 2'd0;
                    case (inram_q[15:12])
                        OP_NOP:            state_d = S_FETCH;
                        OP_WRITE, OP_READ: begin
                            need_arg_s = 1'b1;
                            state_d    = S_ARG;
                        end
                        OP_DELAY: begin
                            cnt_d   = {4'd0, inram_q[11:0]};
                            state_d = S_DELAY;
                        end
                        default:           fail_s = 1'b1;
                    endcase
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_ARG: begin
                if (rvalid_q) begin
                    argi_d = argi_q + 2'd1;
                    case (argi_q)
                        2'd0:    reg_addr_d     = inram_q[13:0];
                        2'd1:    wdata_d[31:16] = inram_q;
                        default: wdata_d[15:0]  = inram_q;
                    endcase
                    if (op_q == OP_READ) begin
                        // both result words must fit below the top of the result RAM
                        if ((32'(out_len_q) + 32'd2) > ADDR_MAX) begin
                            fail_s = 1'b1;
                        end else begin
                            reg_rd_d = 1'b1;
                            cnt_d    = 16'd0;
                            state_d  = S_REG_RD;
                        end
                    end else if (argi_q == 2'd2) begin
                        reg_wr_d = 1'b1;
                        cnt_d    = 16'd0;
                        state_d  = S_REG_WR;
                    end else begin
                        need_arg_s = 1'b1;
                    end
                end else begin
                    state_d = S_ARG;
                end
            end
            S_REG_WR, S_REG_RD: begin
                if (reg_ready_c2) begin
                    reg_rd_d = 1'b0;
                    reg_wr_d = 1'b0;
                    rdata_d  = reg_readdata_c2;
                    state_d  = (state_q == S_REG_RD) ? S_STORE_HI : S_FETCH;
                end else if (cnt_q == TIMEOUT_M1) begin
                    fail_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STORE_HI: begin
                we_d       = 1'b1;
                out_addr_d = out_len_q + AW'(1);
                out_data_d = rdata_q[31:16];
                state_d    = S_STORE_LO;
            end
            S_STORE_LO: begin
                we_d       = 1'b1;
                out_addr_d = out_len_q + AW'(2);
                out_data_d = rdata_q[15:0];
                out_len_d  = out_len_q + AW'(2);
                state_d    = S_FETCH;
            end
            S_DELAY: begin
                if (cnt_q <= 16'd1) begin
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        arg_oob_s = need_arg_s && (ptr_q >= len_q);
        if (need_arg_s && !arg_oob_s) begin
            re_d      = 1'b1;
            in_addr_d = ptr_q;
            ptr_d     = ptr_q + AW'(1);
        end else begin
            re_d = re_d;
        end

        if (fail_s || arg_oob_s) begin
            err_d    = 1'b1;
            reg_rd_d = 1'b0;
            reg_wr_d = 1'b0;
            re_d     = 1'b0;
            state_d  = S_DONE;
        end else begin
            err_d = err_d;
        end
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            len_q      <= '0;
            out_len_q  <= '0;
            in_addr_q  <= '0;
            out_addr_q <= '0;
            out_data_q <= 16'd0;
            op_q       <= 4'd0;
            argi_q     <= 2'd0;
            cnt_q      <= 16'd0;
            reg_addr_q <= 14'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            rvalid_q   <= 1'b0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            reg_rd_q   <= 1'b0;
            reg_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            out_len_q  <= out_len_d;
            in_addr_q  <= in_addr_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            op_q       <= op_d;
            argi_q     <= argi_d;
            cnt_q      <= cnt_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= re_q;
            re_q       <= re_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            reg_rd_q   <= reg_rd_d;
            reg_wr_q   <= reg_wr_d;
        end
    end

    assign inram_address    = in_addr_q;
    assign inram_re         = re_q;
    assign outram_address   = out_addr_q;
    assign outram_we        = we_q;
    assign outram_d         = out_data_q;
    assign reg_addr_c2      = reg_addr_q;
    assign reg_rd_c2        = reg_rd_q;
    assign reg_wr_c2        = reg_wr_q;
    assign reg_writedata_c2 = wdata_q;
    assign busy             = busy_q;
    assign err              = err_q;
    assign out_len          = out_len_q;
endmodule

// File: tb/tb_exec_cmd.sv
// Directed bench for exec_cmd with RAM models and a register-bus responder.
module tb_exec_cmd;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] inram_address, outram_address, out_len, ld_addr, in_addr_mux;
    logic          inram_re, outram_we, reg_rd_c2, reg_wr_c2, reg_ready_c2;
    logic [15:0]   inram_q, outram_d, ld_data, outram_q;
    logic [13:0]   reg_addr_c2;
    logic [31:0]   reg_writedata_c2, reg_readdata_c2;
    logic          start_exec, busy, err, ld_we;

    int n_checks = 0, n_pass = 0;
    int wr_pulses = 0, rd_pulses = 0, rd_hi = 0, both_hi = 0, re_cycles = 0, we_cycles = 0;
    logic          wr_prev = 1'b0, rd_prev = 1'b0;
    logic [13:0]   last_wr_addr = 14'd0, last_rd_addr = 14'd0;
    logic [31:0]   last_wr_data = 32'd0;
    int            ready_lat = 1;
    logic          hang = 1'b0;
    logic [31:0]   rd_value = 32'd0;
    logic [15:0]   prog_q[$];
    int            s_wr, s_rd, s_rdhi, s_re, s_we;

    always #5 clk = ~clk;

    assign in_addr_mux = ld_we ? ld_addr : inram_address;

    exec_cmd #(.AW(AW), .TIMEOUT(255)) dut (
        .clk              (clk),
        .rst              (rst),
        .inram_address    (inram_address),
        .inram_re         (inram_re),
        .inram_q          (inram_q),
        .outram_address   (outram_address),
        .outram_we        (outram_we),
        .outram_d         (outram_d),
        .reg_addr_c2      (reg_addr_c2),
        .reg_rd_c2        (reg_rd_c2),
        .reg_wr_c2        (reg_wr_c2),
        .reg_writedata_c2 (reg_writedata_c2),
        .reg_ready_c2     (reg_ready_c2),
        .reg_readdata_c2  (reg_readdata_c2),
        .start_exec       (start_exec),
        .busy             (busy),
        .err              (err),
        .out_len          (out_len)
    );

    inputram #(.AW(AW)) u_inram (
        .address (in_addr_mux), .clock (clk), .data (ld_data),
        .rden (inram_re), .wren (ld_we), .q (inram_q)
    );

    generic_spram #(.LAT(1), .AW(AW), .DW(16)) u_outram (
        .clk (clk), .re (1'b0), .we (outram_we), .addr (outram_address),
        .data (outram_d), .q (outram_q)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog_q.size(); i++) begin
            @(posedge clk); #1;
            ld_we = 1'b1; ld_addr = 10'(i); ld_data = prog_q[i];
        end
        @(posedge clk); #1;
        ld_we = 1'b0;
    endtask

    task automatic snap();
        s_wr = wr_pulses; s_rd = rd_pulses; s_rdhi = rd_hi; s_re = re_cycles; s_we = we_cycles;
    endtask

    task automatic run_prog(input int budget);
        int cyc;
        snap();
        start_exec = 1'b1;
        @(posedge clk); #1;
        start_exec = 1'b0;
        check_val("busy_rise", {31'd0, busy}, 32'd1);
        check_val("magic_we", {31'd0, outram_we}, 32'd1);
        check_val("magic_d", {16'd0, outram_d}, 32'h0000CBAE);
        check_val("err_clr", {31'd0, err}, 32'd0);
        cyc = 0;
        while (busy === 1'b1 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    // register-bus responder: ready after ready_lat request cycles unless hung
    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        reg_ready_c2 = 1'b0;
        reg_readdata_c2 = 32'd0;
        forever begin
            @(posedge clk); #1;
            if ((reg_rd_c2 || reg_wr_c2) && !reg_ready_c2 && !hang) begin
                wait_cnt++;
                if (wait_cnt >= ready_lat) begin
                    reg_ready_c2 = 1'b1;
                    reg_readdata_c2 = rd_value;
                end
            end else begin
                reg_ready_c2 = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // bus and RAM activity monitor
    always @(negedge clk) begin
        if (reg_wr_c2 && !wr_prev) wr_pulses++;
        if (reg_rd_c2 && !rd_prev) rd_pulses++;
        if (reg_rd_c2) rd_hi++;
        if (reg_rd_c2 && reg_wr_c2) both_hi++;
        if (inram_re) re_cycles++;
        if (outram_we) we_cycles++;
        if (reg_wr_c2 && reg_ready_c2) begin
            last_wr_addr = reg_addr_c2;
            last_wr_data = reg_writedata_c2;
        end
        if (reg_rd_c2 && reg_ready_c2) last_rd_addr = reg_addr_c2;
        wr_prev = reg_wr_c2;
        rd_prev = reg_rd_c2;
    end

    initial begin
        rst = 1'b0; start_exec = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        check_val("rst_strobes", {28'd0, inram_re, outram_we, reg_rd_c2, reg_wr_c2}, 32'd0);
        check_val("rst_out_len", {22'd0, out_len}, 32'd0);
        check_val("rst_addrs", {12'd0, inram_address, outram_address}, 32'd0);
        check_val("rst_reg_addr", {18'd0, reg_addr_c2}, 32'd0);
        check_val("rst_wdata", reg_writedata_c2, 32'd0);
        check_val("rst_outram_d", {16'd0, outram_d}, 32'd0);
        rst = 1'b1;

        // WRITE 0x105 <- 0x12345678
        prog_q = '{16'd5, 16'h1000, 16'h0105, 16'h1234, 16'h5678, 16'hCBAE};
        ready_lat = 2;
        load_prog();
        run_prog(100);
        check_val("wr_pulses", 32'(wr_pulses - s_wr), 32'd1);
        check_val("wr_no_rd", 32'(rd_pulses - s_rd), 32'd0);
        check_val("wr_addr", {18'd0, last_wr_addr}, 32'h105);
        check_val("wr_data", last_wr_data, 32'h12345678);
        check_val("wr_err", {31'd0, err}, 32'd0);
        check_val("wr_out_len", {22'd0, out_len}, 32'd0);
        check_val("outram0", {16'd0, u_outram.mem[0]}, 32'h0000CBAE);

        // NOP, DELAY 2, WRITE with high address bits set
        prog_q = '{16'd7, 16'h0000, 16'h3002, 16'h1000, 16'hC0AA, 16'h0000, 16'h0001, 16'hCBAE};
        ready_lat = 1;
        load_prog();
        run_prog(100);
        check_val("mix_wr_addr", {18'd0, last_wr_addr}, 32'h0AA);
        check_val("mix_wr_data", last_wr_data, 32'h00000001);
        check_val("mix_err", {31'd0, err}, 32'd0);

        // bad opcode
        prog_q = '{16'd2, 16'h7000, 16'hCBAE};
        load_prog();
        run_prog(100);
        check_val("bad_err", {31'd0, err}, 32'd1);
        check_val("bad_strobes", 32'((wr_pulses - s_wr) + (rd_pulses - s_rd)), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_val("bad_err_hold", {31'd0, err}, 32'd1);

        // READ 0x1FE -> 0xDEADBEEF, ready in the third request cycle
        prog_q = '{16'd3, 16'h2000, 16'h01FE, 16'hCBAE};
        ready_lat = 3; rd_value = 32'hDEADBEEF;
        load_prog();
        run_prog(100);
        check_val("rd_pulses", 32'(rd_pulses - s_rd), 32'd1);
        check_val("rd_addr", {18'd0, last_rd_addr}, 32'h1FE);
        check_val("outram1", {16'd0, u_outram.mem[1]}, 32'h0000DEAD);
        check_val("outram2", {16'd0, u_outram.mem[2]}, 32'h0000BEEF);
        check_val("rd_out_len", {22'd0, out_len}, 32'd2);
        check_val("rd_err", {31'd0, err}, 32'd0);

        // READ whose argument sits at index L
        prog_q = '{16'd2, 16'h2000, 16'hCBAE};
        load_prog();
        run_prog(100);
        check_val("oob_err", {31'd0, err}, 32'd1);
        check_val("oob_no_rd", 32'(rd_pulses - s_rd), 32'd0);
        check_val("oob_out_len", {22'd0, out_len}, 32'd0);

        // length too small, then too large
        prog_q = '{16'd1};
        load_prog();
        run_prog(100);
        check_val("len_small_err", {31'd0, err}, 32'd1);
        prog_q = '{16'hFFFF};
        load_prog();
        run_prog(100);
        check_val("len_big_err", {31'd0, err}, 32'd1);

        // READ timeout
        prog_q = '{16'd3, 16'h2000, 16'h0010, 16'hCBAE};
        hang = 1'b1;
        load_prog();
        run_prog(400);
        hang = 1'b0;
        check_val("to_rd_cycles", 32'(rd_hi - s_rdhi), 32'd255);
        check_val("to_err", {31'd0, err}, 32'd1);
        check_val("to_rd_low", {31'd0, reg_rd_c2}, 32'd0);
        check_val("no_overlap", 32'(both_hi), 32'd0);

        // start while busy is ignored; reset mid DELAY aborts
        prog_q = '{16'd3, 16'h30FF, 16'h0000, 16'hCBAE};
        load_prog();
        start_exec = 1'b1;
        @(posedge clk); #1;
        start_exec = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        snap();
        start_exec = 1'b1;
        @(posedge clk); #1;
        start_exec = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("busy_held", {31'd0, busy}, 32'd1);
        check_val("restart_ignored", 32'(we_cycles - s_we), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_strobes", {28'd0, inram_re, outram_we, reg_rd_c2, reg_wr_c2}, 32'd0);
        rst = 1'b1;
        snap();
        repeat (10) @(posedge clk);
        #1;
        check_val("abort_quiet", 32'((re_cycles - s_re) + (we_cycles - s_we)), 32'd0);
        check_val("abort_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/exec_cmd.md
EXEC_CMD -- requirements
Module: exec_cmd

Interface
REQ-001 Parameter AW, default 10: command/result RAM address width in 16-bit words.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for reg_ready_c2.
REQ-003 Ports clk (in, 1) and rst (in, 1): one clock; reset is synchronous and active-low.
REQ-004 inram_address out AW: command RAM word address.
REQ-005 inram_re out 1: command RAM read enable.
REQ-006 inram_q in 16: command RAM data, valid one cycle after inram_re.
REQ-007 outram_address out AW: result RAM word address.
REQ-008 outram_we out 1: result RAM write strobe.
REQ-009 outram_d out 16: result RAM write data.
REQ-010 reg_addr_c2 out 14, reg_rd_c2 out 1, reg_wr_c2 out 1, reg_writedata_c2 out 32: register-bus request.
REQ-011 reg_ready_c2 in 1, reg_readdata_c2 in 32: register-bus completion and read data.
REQ-012 start_exec in 1: start pulse.
REQ-013 busy out 1: execution in progress.
REQ-014 err out 1: last run failed.
REQ-015 out_len out AW: index of the last result word written.

Function
REQ-016 Command RAM layout: word0 = L, the index of the terminating word 0xCBAE; commands occupy words 1..L-1.
REQ-017 Opcode field is word[15:12]; WRITE=1 (+addr word, data_hi, data_lo), READ=2 (+addr word), DELAY=3 (word[11:0] = idle cycles), NOP=0.
REQ-018 Address words use bits [13:0]; bits [15:14] are ignored.
REQ-019 start_exec while busy=0: busy=1 the next cycle; err and out_len clear; outram word0 is written with 0xCBAE.
REQ-020 start_exec while busy=1 is ignored.
REQ-021 FSM states: IDLE, RD_LEN, FETCH, DECODE, ARG, REG_WR, REG_RD, STORE_HI, STORE_LO, DELAY, DONE.
REQ-022 Each fetch asserts inram_re for one cycle; the data is consumed the following cycle.
REQ-023 Execution ends without error when the fetch address equals L; the terminator word is not interpreted.
REQ-024 WRITE: reg_wr_c2=1 with reg_addr_c2 = addr and reg_writedata_c2 = {hi,lo}, held until the cycle reg_ready_c2=1; it drops the next cycle.
REQ-025 READ: reg_rd_c2 held the same way; reg_readdata_c2 is captured in the ready cycle.
REQ-026 READ result: [31:16] is written at outram_address n+1, [15:0] at n+2; out_len increments by 2.
REQ-027 reg_rd_c2 and reg_wr_c2 are never high together.
REQ-028 A reg request is asserted at most once per command.
REQ-029 DELAY n: idle n cycles; n=0 is one cycle.
REQ-030 Errors, each setting err=1 and ending the run: unknown opcode; any argument word at index >= L; L < 2 or L > 2^AW-1; no reg_ready_c2 within TIMEOUT cycles of request assertion.
REQ-031 On an error, any outstanding reg strobe drops the next cycle.
REQ-032 Run end: DONE for one cycle, then busy=0; err and out_len stay valid and stable until the next start.
REQ-033 Result writes never exceed address 2^AW-1; a READ that would overflow is an error and nothing is written.

Reset
REQ-034 rst=0 at a clock edge: FSM to IDLE; busy, err, inram_re, outram_we, reg_rd_c2, reg_wr_c2 = 0; out_len, addresses, reg_addr_c2, reg_writedata_c2, outram_d = 0.
REQ-035 Reset mid-run aborts immediately and issues no further RAM or reg accesses.

Structure
REQ-036 A shared package holds the opcode constants, MAGIC_WORD 16'hCBAE, and the default TIMEOUT.
REQ-037 The RAMs are external to exec_cmd.
REQ-038 Benches model the RAMs with sub-module generic_spram (params: read latency 1, AW, width 16; ports clk, re, we, addr, data, q); q updates only when re=1.
REQ-039 inputram is the synthesis wrapper with the same behaviour (ports address, clock, data, rden, wren, q).

Verification
REQ-040 Scenario, WRITE: RAM {4, 0x1000, 0x0105, 0x0000, ...} is not valid (WRITE needs 3 args); use {5, 0x1000, 0x0105, 0x1234, 0x5678, 0xCBAE} -> one reg_wr_c2 pulse, addr 0x105, data 0x12345678; err=0; out_len=0.
REQ-041 Scenario, READ: {3, 0x2000, 0x01FE, 0xCBAE}, readdata 0xDEADBEEF with ready after 3 cycles -> outram[1]=0xDEAD, outram[2]=0xBEEF, out_len=2, err=0.
REQ-042 Scenario, bad opcode: {2, 0x7000, 0xCBAE} -> err=1, no reg strobes, busy falls.
REQ-043 Scenario, timeout: READ with reg_ready_c2 held 0 -> reg_rd_c2 drops after 255 cycles, err=1.
REQ-044 Scenario, busy and reset: start_exec pulsed while busy -> ignored; rst=0 during a DELAY 0x0FF -> busy=0 next cycle, all strobes 0.
